uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync2.sv | 33 +++
 rtl/uart_rx.sv | 130 +++++++++++++
 tb/tb_uart_rx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default bit timing.
// Combinational only, no latency. No backpressure.
// The transmitter is meant to reuse these definitions.
package uart_pkg;

    // 100 MHz core clock at 115200 baud.
    localparam int CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for one asynchronous bit, with a configurable reset value.
// Latency: 2 clk. No backpressure.
// The reset value should match the idle level of the line.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, frame-error detection and break hold-off.
// Latency: valid fires about 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clk after the start edge.
// No backpressure: each pulse lasts one cycle, and data holds until the next good frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);

    logic rxs;

    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            cnt_zero;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxs)
    );

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    state_d = ST_START;
                    cnt_d   = HALF_RELOAD;
                end
            end
            ST_START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rxs) begin
                    // The low level did not last to mid-bit, so treat it as a glitch.
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                    cnt_d   = FULL_RELOAD;
                    idx_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shift_d[idx_q] = rxs;
                    cnt_d          = FULL_RELOAD;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rxs) begin
                    // Leaving at mid-stop lets a back-to-back start bit be caught.
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    ferr_d  = 1'b1;
                    state_d = ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized bench for uart_rx at 16 clocks per bit.
// A line-level frame model predicts the bytes and frame errors.
module tb_uart_rx;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log every valid pulse with its cycle, and count frame errors.
    logic [7:0] v_data[$];
    int         v_cyc[$];
    int         ferr_cnt = 0;
    int         both_cnt = 0;

    always @(negedge clk) begin
        if (valid) begin
            v_data.push_back(data);
            v_cyc.push_back(cyc);
        end
        if (frame_err) ferr_cnt++;
        if (valid && frame_err) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        cycles(N);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    int         st, dlt, n0, f0, gap, exp_ferr;
    logic [7:0] b, last_good;
    logic       stop;
    logic [7:0] exp_q[$];

    initial begin
        // Reset state
        cycles(3);
        chk("rst_data", data, 8'h00);
        chk("rst_valid", valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        cycles(3);

        // Good frame 0xA5
        n0 = v_data.size(); f0 = ferr_cnt; st = cyc;
        send_frame(8'hA5, 1'b1);
        chk("a5_count", v_data.size(), n0 + 1);
        if (v_data.size() > n0) begin
            chk("a5_data", v_data[n0], 8'hA5);
            dlt = v_cyc[n0] - st;
            chk("a5_latency", (dlt >= 153 && dlt <= 155), 1);
        end
        chk("a5_port", data, 8'hA5);
        chk("a5_noferr", ferr_cnt, f0);
        chk("a5_busy_low", busy, 0);

        // False start: 4 low cycles
        n0 = v_data.size();
        rxd = 1'b0;
        cycles(4);
        chk("fs_busy_high", busy, 1);
        rxd = 1'b1;
        cycles(8);
        chk("fs_busy_low", busy, 0);
        chk("fs_novalid", v_data.size(), n0);
        chk("fs_noferr", ferr_cnt, f0);

        // Bad stop on 0x3C, then break
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(((8'h3C >> i) & 8'h01) != 0);
        send_bit(1'b0);
        cycles(40);
        chk("fe_count", ferr_cnt, f0 + 1);
        chk("fe_busy_break", busy, 1);
        chk("fe_data_kept", data, 8'hA5);
        rxd = 1'b1;
        cycles(4);
        chk("fe_busy_low", busy, 0);
        chk("fe_novalid", v_data.size(), n0);
        cycles(N);

        // Back-to-back 0x00, 0xFF
        n0 = v_data.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        cycles(N);
        chk("b2b_count", v_data.size(), n0 + 2);
        if (v_data.size() >= n0 + 2) begin
            chk("b2b_first", v_data[n0], 8'h00);
            chk("b2b_second", v_data[n0+1], 8'hFF);
            dlt = v_cyc[n0+1] - v_cyc[n0];
            chk("b2b_spacing", (dlt >= 159 && dlt <= 161), 1);
        end

        // Reset during bit 4 of 0x5A
        n0 = v_data.size(); f0 = ferr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(((8'h5A >> i) & 8'h01) != 0);
        rxd = 1'b1;
        cycles(N / 2);
        rst = 1'b0;
        cycles(2);
        chk("mid_rst_data", data, 8'h00);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_ferr", frame_err, 0);
        chk("mid_rst_busy", busy, 0);
        cycles(3);
        rst = 1'b1;
        cycles(2 * N);
        chk("abort_novalid", v_data.size(), n0);
        send_frame(8'hC3, 1'b1);
        cycles(N);
        chk("c3_count", v_data.size(), n0 + 1);
        if (v_data.size() > n0) chk("c3_data", v_data[n0], 8'hC3);
        chk("abort_noferr", ferr_cnt, f0);

        // Random frames. The model expects the byte when stop is high; otherwise a frame error with data held.
        n0 = v_data.size(); f0 = ferr_cnt; exp_ferr = 0; last_good = 8'hC3;
        for (int k = 0; k < 12; k++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            gap  = $urandom_range(0, 2);
            send_frame(b, stop);
            if (stop) begin
                exp_q.push_back(b);
                last_good = b;
            end else begin
                exp_ferr++;
                rxd = 1'b0;
                cycles($urandom_range(0, 20));
                gap = gap + 1;
            end
            repeat (gap) send_bit(1'b1);
        end
        cycles(N);
        chk("rnd_count", v_data.size(), n0 + exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (n0 + i < v_data.size()) chk("rnd_data", v_data[n0+i], exp_q[i]);
        end
        chk("rnd_ferr", ferr_cnt, f0 + exp_ferr);
        chk("rnd_port", data, last_good);
        chk("never_both", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
